// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: instruction in, stall/busy/perf counter out.
interface hazard_scoreboard_if #(
    parameter int STALL_CNT_W = 32
) ();
    logic [31:0]            instr;
    logic                   instr_valid;
    logic                   stall;
    logic [15:0]            busy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output instr,
        output instr_valid,
        input  stall,
        input  busy,
        input  stall_cycles
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output stall,
        output busy,
        output stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: per-register countdown of in-flight writes driving decode stall.
// Optional macro HAZARD_FORWARD_EN: execute->decode forwarding, only the adjacent consumer waits.
module hazard_scoreboard #(
    parameter int WB_LAT      = 2,
    parameter int STALL_CNT_W = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);
    localparam int CW = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(WB_LAT);

    if (WB_LAT < 1) begin : g_bad_lat
        $error("hazard_scoreboard: WB_LAT must be at least 1");
    end

    logic [CW-1:0]          cnt [16];
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic       imb;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_nop;
    logic       rb_used;
    logic       src_hazard;
    logic       pc_hold;
    logic       stall_int;
    logic       issue;

    function automatic logic hazard(input logic [CW-1:0] c);
`ifdef HAZARD_FORWARD_EN
        return c == LAT;
`else
        return c != '0;
`endif
    endfunction

    assign imb = bus.instr[31];
    assign ra  = bus.instr[30:27];
    assign rb  = bus.instr[26:23];
    assign rc  = bus.instr[7:4];

    // Rb is only a register source for non-immediate forms and ordinary registers;
    // pc/overflow can only be named through Ra.
    always_comb begin
        is_nop     = !bus.instr_valid || (bus.instr == 32'h0);
        rb_used    = !imb && (rb < 4'd14);
        src_hazard = hazard(cnt[ra]) || (rb_used && hazard(cnt[rb]));
        pc_hold    = cnt[14] != '0;
        stall_int  = !rst && ((!is_nop && src_hazard) || pc_hold);
        issue      = !is_nop && !stall_int;
    end

    always_comb begin
        bus.busy = '0;
        for (int i = 0; i < 16; i++) begin
            bus.busy[i] = cnt[i] != '0;
        end
    end

    assign bus.stall        = stall_int;
    assign bus.stall_cycles = stall_cnt;

    // A newly issued writer reloads its destination even if a prior write is still
    // counting down (WAW); the younger write defines when the register is final.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (issue && (rc == 4'(i))) begin
                    cnt[i] <= LAT;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule
